// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int MEM_ADDR_W  = 28;

  // Controller states (legacy-compatible encoding)
  // state        | meaning
  // S_IDLE       | serve hits, detect misses, accept flush
  // S_WRITEBACK  | write the dirty victim block to memory
  // S_ALLOCATE   | read the missing block from memory
  // S_UPDATE     | install the fetched block, then retry in IDLE
  // S_FLUSH_SCAN | walk line indices looking for dirty lines
  // S_FLUSH_WB   | write back one dirty line found by the scan
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_WRITEBACK  = 3'd1;
  localparam state_t S_ALLOCATE   = 3'd2;
  localparam state_t S_UPDATE     = 3'd3;
  localparam state_t S_FLUSH_SCAN = 3'd4;
  localparam state_t S_FLUSH_WB   = 3'd5;

  // CPU byte address split into block address, word select and byte offset.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] blk;
    logic [1:0]            word;
    logic [1:0]            byte_off;
  } cpu_addr_t;

endpackage

// File: rtl/dcache_line_store.sv
// Cache line arrays: valid/dirty flags (async cleared), tags and block data.
// One full-line write port, one combinational read port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic             o_rd_dirty,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [127:0]     o_rd_data,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_valid,
  input  logic             i_wr_dirty,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [127:0]     i_wr_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];

  // Line flags: cleared by reset so every line starts invalid and clean
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= i_wr_valid;
      r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end

  // Tag and data payload: meaningless until the valid bit is set
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller with flush.
// Memory request signals decode from state only, so they drop on the edge
// that completes a transfer.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_address,
  input  logic [31:0]           cpu_writedata,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_busywait,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [127:0]          mem_writedata,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait
);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_flush_pend;

  cpu_addr_t        w_addr;
  logic [IDX_W-1:0] w_cpu_idx;
  logic [TAG_W-1:0] w_cpu_tag;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_valid, w_rd_dirty, w_line_dirty;
  logic [TAG_W-1:0] w_rd_tag;
  logic [127:0]     w_rd_data, w_merged;
  logic             w_req, w_idle, w_hit, w_last, w_mem_done;
  logic             w_wb_state, w_in_flush, w_flush_go;
  logic             w_we, w_wr_valid, w_wr_dirty;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic [127:0]     w_wr_data;
  logic             w_unused;

  assign w_addr     = cpu_address;
  assign w_cpu_idx  = w_addr.blk[IDX_W-1:0];
  assign w_cpu_tag  = w_addr.blk[MEM_ADDR_W-1:IDX_W];
  assign w_unused   = ^w_addr.byte_off;

  assign w_req        = cpu_read | cpu_write;
  assign w_idle       = (r_state == S_IDLE);
  // Outside IDLE the latched index addresses the victim or the flush cursor.
  assign w_rd_idx     = w_idle ? w_cpu_idx : r_idx;
  assign w_hit        = w_rd_valid && (w_rd_tag == w_cpu_tag);
  assign w_line_dirty = w_rd_valid && w_rd_dirty;
  assign w_last       = (r_idx == IDX_W'(NUM_LINES - 1));
  assign w_mem_done   = !mem_busywait;
  assign w_wb_state   = (r_state == S_WRITEBACK) || (r_state == S_FLUSH_WB);
  assign w_in_flush   = (r_state == S_FLUSH_SCAN) || (r_state == S_FLUSH_WB);
  assign w_flush_go   = w_idle && !w_req && (flush || r_flush_pend);

  assign cpu_busywait  = !reset && w_req && !(w_idle && w_hit);
  assign cpu_readdata  = (w_idle && w_hit) ? w_rd_data[{w_addr.word, 5'd0} +: 32] : '0;
  assign mem_read      = (r_state == S_ALLOCATE);
  assign mem_write     = w_wb_state;
  assign mem_address   = w_wb_state ? {w_rd_tag, r_idx} : (mem_read ? {r_tag, r_idx} : '0);
  assign mem_writedata = w_wb_state ? w_rd_data : '0;
  assign flush_done    = ((r_state == S_FLUSH_SCAN) && w_last && !w_line_dirty) ||
                         ((r_state == S_FLUSH_WB) && w_mem_done && w_last);

  // Store word merged into the current line for a write hit
  always_comb begin
    w_merged = w_rd_data;
    w_merged[{w_addr.word, 5'd0} +: 32] = cpu_writedata;
  end

  // Line-store write port: write hit, block install, or dirty clear after flush write-back
  always_comb begin
    w_we       = 1'b0;
    w_wr_idx   = r_idx;
    w_wr_valid = 1'b1;
    w_wr_dirty = 1'b0;
    w_wr_tag   = w_rd_tag;
    w_wr_data  = w_rd_data;
    case (r_state)
      S_IDLE: begin
        if (cpu_write && w_hit) begin
          w_we       = 1'b1;
          w_wr_idx   = w_cpu_idx;
          w_wr_dirty = 1'b1;
          w_wr_tag   = w_cpu_tag;
          w_wr_data  = w_merged;
        end
      end
      S_UPDATE: begin
        w_we      = 1'b1;
        w_wr_tag  = r_tag;
        w_wr_data = mem_readdata;
      end
      S_FLUSH_WB: w_we = w_mem_done;
      default: w_we = 1'b0;
    endcase
  end

  // Controller FSM plus latched miss address / flush cursor and pending flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_tag        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_flush_go)
        r_flush_pend <= 1'b0;
      else if (flush && !w_in_flush)
        r_flush_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_idx   <= w_cpu_idx;
            r_tag   <= w_cpu_tag;
            r_state <= w_line_dirty ? S_WRITEBACK : S_ALLOCATE;
          end else if (w_flush_go) begin
            r_idx   <= '0;
            r_state <= S_FLUSH_SCAN;
          end
        end
        S_WRITEBACK: if (w_mem_done) r_state <= S_ALLOCATE;
        S_ALLOCATE:  if (w_mem_done) r_state <= S_UPDATE;
        S_UPDATE:    r_state <= S_IDLE;
        S_FLUSH_SCAN: begin
          if (w_line_dirty)
            r_state <= S_FLUSH_WB;
          else if (w_last)
            r_state <= S_IDLE;
          else
            r_idx <= r_idx + 1'b1;
        end
        S_FLUSH_WB: begin
          if (w_mem_done) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FLUSH_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .i_rd_idx   (w_rd_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_dirty (w_rd_dirty),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_we),
    .i_wr_idx   (w_wr_idx),
    .i_wr_valid (w_wr_valid),
    .i_wr_dirty (w_wr_dirty),
    .i_wr_tag   (w_wr_tag),
    .i_wr_data  (w_wr_data)
  );

endmodule
